// File: rtl/router_reg.sv
// -----------------------------------------------------------------------------
// router_reg -- datapath register stage of the 1x3 router.
//
// Sits between router_fsm and the three output FIFOs. Driven by the FSM's
// one-hot state strobes, it:
//   - latches the header byte on detect_add,
//   - forwards the header and payload bytes to dout,
//   - parks one byte in hold_byte while the destination FIFO is full, and
//     replays it in laf_state,
//   - accumulates running parity and compares it against the packet's
//     parity byte.
//
// Parameters
//   WIDTH         data byte width. data_in[1:0] is the destination address
//                 and data_in[WIDTH-1:2] is the payload length.
//
// Ports
//   clock         rising-edge clock
//   reset         asynchronous, active-high reset
//   pkt_valid     source byte valid; low on the parity byte
//   data_in       source byte (header, payload or parity)
//   fifo_full     selected destination FIFO is full
//   detect_add    FSM strobe: header byte on data_in
//   lfd_state     FSM strobe: load first data (header) into FIFO
//   ld_state      FSM strobe: load payload/parity data
//   laf_state     FSM strobe: load the byte held after a full FIFO
//   full_state    FSM strobe: waiting on a full FIFO
//   rst_int_reg   FSM request to clear low_pkt_valid
//   parity_done   parity byte has been consumed (sticky until detect_add)
//   low_pkt_valid pkt_valid dropped while in ld_state
//   err           received parity differs from the computed parity
//   dout          byte to the FIFO write port
//
// Build option
//   ROUTER_REG_PARITY_CHECK_EN  when defined, the parity accumulator, the
//   received-parity register and the err logic are built. When undefined
//   they are left out and err is tied to 0.
// -----------------------------------------------------------------------------
module router_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pkt_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic             fifo_full,
  input  logic             detect_add,
  input  logic             lfd_state,
  input  logic             ld_state,
  input  logic             laf_state,
  input  logic             full_state,
  input  logic             rst_int_reg,
  output logic             parity_done,
  output logic             low_pkt_valid,
  output logic             err,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] header_byte;
  logic [WIDTH-1:0] hold_byte;

  // Winning strobe after priority resolution. The FSM should only ever raise
  // one strobe; if it raises several, detect_add > lfd > ld > laf.
  logic lfd_win;
  logic ld_win;
  logic laf_win;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the block leaves it unassigned (which would infer a latch).
    lfd_win = 1'b0;
    ld_win  = 1'b0;
    laf_win = 1'b0;
    if (!detect_add) begin
      if (lfd_state)      lfd_win = 1'b1;
      else if (ld_state)  ld_win  = 1'b1;
      else if (laf_state) laf_win = 1'b1;
    end
  end

  // Header capture. Address 2'b11 is not a valid port, so that header is
  // dropped and the previous header_byte is kept.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its inputs.
      header_byte <= '0;
    end else if (detect_add && pkt_valid && (data_in[1:0] != 2'b11)) begin
      header_byte <= data_in;
    end
  end

  // Byte path to the FIFO. A byte that arrives while the FIFO is full is
  // parked in hold_byte, and dout keeps its last value until laf_state
  // replays the parked byte. dout also holds in full_state and in idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout      <= '0;
      hold_byte <= '0;
    end else if (lfd_win) begin
      dout <= header_byte;
    end else if (ld_win) begin
      if (fifo_full) hold_byte <= data_in;
      else           dout      <= data_in;
    end else if (laf_win) begin
      dout <= hold_byte;
    end
  end

  // The parity byte (pkt_valid low in ld_state) is flagged here. The flag
  // persists until the FSM clears it, and a clear wins over a new set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      low_pkt_valid <= 1'b0;
    end else if (rst_int_reg) begin
      low_pkt_valid <= 1'b0;
    end else if (ld_win && !pkt_valid) begin
      low_pkt_valid <= 1'b1;
    end
  end

  // The parity byte is consumed either directly (FIFO had room) or when it
  // is replayed from hold_byte in laf_state. parity_done stays set until the
  // next header arrives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      parity_done <= 1'b0;
    end else if (detect_add) begin
      parity_done <= 1'b0;
    end else if ((ld_win && !pkt_valid && !fifo_full) ||
                 (laf_win && low_pkt_valid && !parity_done)) begin
      parity_done <= 1'b1;
    end
  end

`ifdef ROUTER_REG_PARITY_CHECK_EN
  logic [WIDTH-1:0] int_parity;
  logic [WIDTH-1:0] pkt_parity;

  // Running XOR of header and payload bytes. A payload byte is counted in the
  // cycle it is presented, even when it is diverted to hold_byte, so replaying
  // it from laf_state must not count it a second time.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      int_parity <= '0;
      pkt_parity <= '0;
      err        <= 1'b0;
    end else begin
      if (detect_add)
        int_parity <= '0;
      else if (lfd_win)
        int_parity <= int_parity ^ header_byte;
      else if (ld_win && pkt_valid && !full_state)
        int_parity <= int_parity ^ data_in;

      if (ld_win && !pkt_valid)
        pkt_parity <= data_in;

      // err is compared on the edge after parity_done rises, then keeps being
      // refreshed with the same (now stable) operands until detect_add.
      if (detect_add)
        err <= 1'b0;
      else if (parity_done)
        err <= (int_parity != pkt_parity);
    end
  end
`else
  // full_state only gates parity accumulation, so it has no load here.
  logic unused_full_state;
  assign unused_full_state = full_state;
  assign err               = 1'b0;
`endif

endmodule
